// File: rtl/mainfsm_pkg.sv
// rtl/mainfsm_pkg.sv - shared types and constants for the multicycle controller
// Purpose: state encoding, instruction-class codes and datapath mux selects
//          used by the mainfsm controller and its testbench.
package mainfsm_pkg;

  // 4-bit state encoding; FETCH must stay 0 so reset lands there.
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } statetype;

  // Instruction class (IR[27:26]); 2'b11 is undecodable.
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_B   = 2'b10;

  // ALU A-operand select
  localparam logic [1:0] SRCA_REG  = 2'b00;
  localparam logic [1:0] SRCA_PC   = 2'b01;

  // ALU B-operand select
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result mux select
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/mainfsm.sv
// rtl/mainfsm.sv - multicycle controller FSM with memory-ready stall
// Purpose: sequences the shared datapath (one memory port, one ALU) by
//          decoding Op/Funct into per-cycle control.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (0 = in reset)
//   Op         instruction class, IR[27:26]
//   Funct      IR[25:20]; bit5 immediate, bit0 load/store L-bit
//   MemReady   memory completed/accepted the access this cycle
//   IRWrite    load instruction register
//   AdrSrc     memory address select (0 PC, 1 ALU result)
//   ALUSrcA    ALU A select
//   ALUSrcB    ALU B select
//   ResultSrc  result mux select
//   NextPC     unconditional PC write request
//   RegW       register write request, gated downstream by condition logic
//   MemW       memory write request, gated downstream by condition logic
//   Branch     branch request, combined with PCS downstream
//   ALUOp      1 = ALU decoder uses Funct, 0 = add
//   Illegal    one-cycle pulse when an undecodable Op reaches decode
//   State      current state encoding for visibility
module mainfsm
  import mainfsm_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic       Illegal,
  output logic [3:0] State
);

  statetype r_state;
  statetype w_next;
  logic     w_mem_ready;
  logic     w_unused_funct;

  // Single-cycle memory builds tie the ready off so stalls never occur.
  assign w_mem_ready    = USE_MEM_READY ? MemReady : 1'b1;
  // Only the immediate and L bits steer sequencing; the rest go to the ALU decoder.
  assign w_unused_funct = ^Funct[4:1];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:    w_next = w_mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (Op)
          OP_MEM:  w_next = MEMADR;
          OP_DP:   w_next = Funct[5] ? EXECUTEI : EXECUTER;
          OP_B:    w_next = BRANCH;
          default: w_next = UNKNOWN;
        endcase
      end
      MEMADR:   w_next = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  w_next = w_mem_ready ? MEMWB : MEMREAD;
      MEMWB:    w_next = FETCH;
      MEMWRITE: w_next = w_mem_ready ? FETCH : MEMWRITE;
      EXECUTER: w_next = ALUWB;
      EXECUTEI: w_next = ALUWB;
      ALUWB:    w_next = FETCH;
      BRANCH:   w_next = FETCH;
      default:  w_next = FETCH;
    endcase
  end

  // Output decode: Moore except IRWrite/NextPC, which follow MemReady in FETCH
  // so the PC only advances once the instruction word has actually arrived.
  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = SRCA_REG;
    ALUSrcB   = SRCB_REG;
    ResultSrc = RES_ALUOUT;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    Illegal   = 1'b0;
    case (r_state)
      FETCH: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        IRWrite   = w_mem_ready;
        NextPC    = w_mem_ready;
      end
      DECODE: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      MEMADR: begin
        ALUSrcB   = SRCB_IMM;
      end
      MEMREAD: begin
        AdrSrc    = 1'b1;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegW      = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc    = 1'b1;
        MemW      = 1'b1;
      end
      EXECUTER: begin
        ALUOp     = 1'b1;
      end
      EXECUTEI: begin
        ALUSrcB   = SRCB_IMM;
        ALUOp     = 1'b1;
      end
      ALUWB: begin
        RegW      = 1'b1;
      end
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALU;
        Branch    = 1'b1;
      end
      default: begin
        // UNKNOWN and unused encodings: flag and drop the instruction.
        Illegal   = 1'b1;
      end
    endcase
  end

  assign State = r_state;

endmodule

// File: tb/tb_mainfsm.sv
// tb/tb_mainfsm.sv - directed self-checking bench for the mainfsm controller
module tb_mainfsm;
  import mainfsm_pkg::*;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MemReady;
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       ALUOp;
  logic       Illegal;
  logic [3:0] State;

  int n_total;
  int n_bad;

  mainfsm #(.USE_MEM_READY(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .Funct     (Funct),
    .MemReady  (MemReady),
    .IRWrite   (IRWrite),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .NextPC    (NextPC),
    .RegW      (RegW),
    .MemW      (MemW),
    .Branch    (Branch),
    .ALUOp     (ALUOp),
    .Illegal   (Illegal),
    .State     (State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word: {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp, Illegal}
  localparam logic [13:0] C_FETCH  = 14'b1_0_01_10_10_1_0_0_0_0_0;
  localparam logic [13:0] C_FSTALL = 14'b0_0_01_10_10_0_0_0_0_0_0;
  localparam logic [13:0] C_DEC    = 14'b0_0_01_10_10_0_0_0_0_0_0;
  localparam logic [13:0] C_MADR   = 14'b0_0_00_01_00_0_0_0_0_0_0;
  localparam logic [13:0] C_MRD    = 14'b0_1_00_00_00_0_0_0_0_0_0;
  localparam logic [13:0] C_MWB    = 14'b0_0_00_00_01_0_1_0_0_0_0;
  localparam logic [13:0] C_MWR    = 14'b0_1_00_00_00_0_0_1_0_0_0;
  localparam logic [13:0] C_EXR    = 14'b0_0_00_00_00_0_0_0_0_1_0;
  localparam logic [13:0] C_AWB    = 14'b0_0_00_00_00_0_1_0_0_0_0;
  localparam logic [13:0] C_BR     = 14'b0_0_00_01_10_0_0_0_1_0_0;
  localparam logic [13:0] C_UNK    = 14'b0_0_00_00_00_0_0_0_0_0_1;

  logic [13:0] w_ctl;
  assign w_ctl = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                  NextPC, RegW, MemW, Branch, ALUOp, Illegal};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs on the falling edge, then check state and
  // control a little later, well away from the rising edge.
  task automatic run(input logic rn, input logic [1:0] op, input logic [5:0] fn,
                     input logic mr, input logic [3:0] exp_st,
                     input logic [13:0] exp_ctl, input string tag);
    @(negedge clk);
    reset    = rn;
    Op       = op;
    Funct    = fn;
    MemReady = mr;
    #1;
    check({tag, ".state"}, {28'd0, State}, {28'd0, exp_st});
    check({tag, ".ctl"}, {18'd0, w_ctl}, {18'd0, exp_ctl});
  endtask

  initial begin
    n_total  = 0;
    n_bad    = 0;
    reset    = 1'b0;
    Op       = 2'b00;
    Funct    = 6'b000100;
    MemReady = 1'b1;

    // Reset held 3 cycles: FETCH values shown, no write requests
    for (int i = 0; i < 3; i++) begin
      run(1'b0, 2'b00, 6'b000100, 1'b1, FETCH, C_FETCH, "rst");
      check("rst.wr", {29'd0, RegW, MemW, Branch}, 32'd0);
    end

    // ADD reg: FETCH, DECODE, EXECUTER, ALUWB
    run(1'b1, 2'b00, 6'b000100, 1'b1, FETCH,    C_FETCH, "add.f");
    run(1'b1, 2'b00, 6'b000100, 1'b1, DECODE,   C_DEC,   "add.d");
    run(1'b1, 2'b00, 6'b000100, 1'b1, EXECUTER, C_EXR,   "add.e");
    run(1'b1, 2'b00, 6'b000100, 1'b1, ALUWB,    C_AWB,   "add.wb");

    // LDR imm with two stalled MEMREAD cycles
    run(1'b1, 2'b01, 6'b011001, 1'b1, FETCH,   C_FETCH, "ldr.f");
    run(1'b1, 2'b01, 6'b011001, 1'b1, DECODE,  C_DEC,   "ldr.d");
    run(1'b1, 2'b01, 6'b011001, 1'b1, MEMADR,  C_MADR,  "ldr.a");
    run(1'b1, 2'b01, 6'b011001, 1'b0, MEMREAD, C_MRD,   "ldr.r0");
    run(1'b1, 2'b01, 6'b011001, 1'b0, MEMREAD, C_MRD,   "ldr.r1");
    run(1'b1, 2'b01, 6'b011001, 1'b1, MEMREAD, C_MRD,   "ldr.r2");
    run(1'b1, 2'b01, 6'b011001, 1'b1, MEMWB,   C_MWB,   "ldr.wb");

    // STR with one stalled FETCH and two stalled MEMWRITE cycles
    run(1'b1, 2'b01, 6'b011000, 1'b0, FETCH,    C_FSTALL, "str.fs");
    run(1'b1, 2'b01, 6'b011000, 1'b1, FETCH,    C_FETCH,  "str.f");
    run(1'b1, 2'b01, 6'b011000, 1'b1, DECODE,   C_DEC,    "str.d");
    run(1'b1, 2'b01, 6'b011000, 1'b1, MEMADR,   C_MADR,   "str.a");
    run(1'b1, 2'b01, 6'b011000, 1'b0, MEMWRITE, C_MWR,    "str.w0");
    run(1'b1, 2'b01, 6'b011000, 1'b0, MEMWRITE, C_MWR,    "str.w1");
    run(1'b1, 2'b01, 6'b011000, 1'b1, MEMWRITE, C_MWR,    "str.w2");

    // Branch
    run(1'b1, 2'b10, 6'b000000, 1'b1, FETCH,  C_FETCH, "b.f");
    run(1'b1, 2'b10, 6'b000000, 1'b1, DECODE, C_DEC,   "b.d");
    run(1'b1, 2'b10, 6'b000000, 1'b1, BRANCH, C_BR,    "b.br");

    // Undecodable Op
    run(1'b1, 2'b11, 6'b000000, 1'b1, FETCH,   C_FETCH, "ill.f");
    run(1'b1, 2'b11, 6'b000000, 1'b1, DECODE,  C_DEC,   "ill.d");
    run(1'b1, 2'b11, 6'b000000, 1'b1, UNKNOWN, C_UNK,   "ill.u");

    // Data-processing immediate, also checks return to FETCH after UNKNOWN
    run(1'b1, 2'b00, 6'b100100, 1'b1, FETCH,    C_FETCH, "dpi.f");
    run(1'b1, 2'b00, 6'b100100, 1'b1, DECODE,   C_DEC,   "dpi.d");
    run(1'b1, 2'b00, 6'b100100, 1'b1, EXECUTEI, 14'b0_0_00_01_00_0_0_0_0_1_0, "dpi.e");
    run(1'b1, 2'b00, 6'b100100, 1'b1, ALUWB,    C_AWB,   "dpi.wb");

    // Reset asserted mid-MEMWRITE aborts at once
    run(1'b1, 2'b01, 6'b011000, 1'b1, FETCH,    C_FETCH, "abt.f");
    run(1'b1, 2'b01, 6'b011000, 1'b1, DECODE,   C_DEC,   "abt.d");
    run(1'b1, 2'b01, 6'b011000, 1'b1, MEMADR,   C_MADR,  "abt.a");
    run(1'b1, 2'b01, 6'b011000, 1'b0, MEMWRITE, C_MWR,   "abt.w");
    reset = 1'b0;
    #1;
    check("abt.memw",  {31'd0, MemW}, 32'd0);
    check("abt.state", {28'd0, State}, {28'd0, FETCH});
    run(1'b0, 2'b01, 6'b011000, 1'b0, FETCH, C_FSTALL, "abt.hold");
    run(1'b1, 2'b01, 6'b011000, 1'b1, FETCH, C_FETCH,  "abt.rel");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mainfsm.md
Name: mainfsm

Overview:
- Multicycle controller FSM that sequences the shared datapath: one memory port, one ALU, IR/PC enables and result mux.
- Decodes Op/Funct into per-cycle control. Emits NextPC, RegW and MemW as the unconditioned requests that the condition-logic stage then gates.
- Adds a memory-ready stall so fetch, load and store can wait on slow memory.

Parameters:
- USE_MEM_READY, 1, when 0 MemReady is ignored and treated as constant 1 (single-cycle memory).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- Op  input  2  instruction class from IR[27:26].
- Funct  input  6  IR[25:20]; bit5 = immediate, bit0 = load/store L-bit.
- MemReady  input  1  memory has completed/accepted the current access this cycle.
- IRWrite  output  1  load instruction register.
- AdrSrc  output  1  0 = PC, 1 = ALU result as memory address.
- ALUSrcA  output  2  ALU A-operand select.
- ALUSrcB  output  2  ALU B-operand select.
- ResultSrc  output  2  result mux select.
- NextPC  output  1  unconditional PC write request.
- RegW  output  1  register write request (pre-condition).
- MemW  output  1  memory write request (pre-condition).
- Branch  output  1  branch-taken request (combined with PCS downstream).
- ALUOp  output  1  1 = ALU decoder uses Funct, 0 = add.
- Illegal  output  1  one-cycle pulse when an undecodable Op reaches decode.
- State  output  4  current state encoding (debug/visibility).

Behaviour:
- Reset (reset==0, asynchronous) forces state FETCH. State registers update on posedge clk only while reset==1.
- Outputs are Moore functions of state, except where MemReady gating is stated below.
- FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUOp=0.
  - IRWrite = NextPC = MemReady.
  - Hold FETCH while MemReady=0; go to DECODE when MemReady=1.
  - Consequence: while reset is held, outputs show FETCH values and the PC advances only with MemReady.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. Next state:
  - Op=01 -> MEMADR.
  - Op=00 with Funct[5]=0 -> EXECUTER.
  - Op=00 with Funct[5]=1 -> EXECUTEI.
  - Op=10 -> BRANCH.
  - Op=11 -> UNKNOWN.
- MEMADR: ALUSrcA=00, ALUSrcB=01, ALUOp=0. Funct[0]=1 -> MEMREAD, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Hold while MemReady=0; -> MEMWB when MemReady=1.
- MEMWB: ResultSrc=01, RegW=1 -> FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1 held every cycle in the state. Hold while MemReady=0; -> FETCH when MemReady=1.
- EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1 -> ALUWB.
- EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1 -> ALUWB.
- ALUWB: ResultSrc=00, RegW=1 -> FETCH.
- BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, ALUOp=0, Branch=1 -> FETCH.
- UNKNOWN: all enables 0, Illegal=1 for exactly one cycle -> FETCH. The instruction is discarded and the PC was already advanced in FETCH.
- Default value for any signal not listed in a state: 0. Unused state encodings decode as UNKNOWN.
- Instruction cycle counts with MemReady tied to 1:
  - Load: 5.
  - Store: 4.
  - Data-processing: 4.
  - Branch: 3.
  - Illegal: 3.
- Reset asserted mid-instruction aborts immediately. No write enable may remain high while reset==0.

Decomposition:
- Shared package mainfsm_pkg holds:
  - state enum statetype, 4-bit encoding, FETCH=0.
  - Op constants OP_DP=00, OP_MEM=01, OP_B=10.
  - Mux-select localparams (SRCA_*, SRCB_*, RES_*).
- No sub-module: a single next-state always_ff plus a combinational output decode.

Test Plan:
- Hold reset=0 for 3 cycles with MemReady=1, then release -> State=FETCH throughout reset; IRWrite=NextPC=1 in the first cycle after release; RegW=MemW=Branch=0 during reset.
- Op=00, Funct=6'b000100 (ADD reg), MemReady=1 -> states FETCH, DECODE, EXECUTER, ALUWB, FETCH. ALUOp=1 in EXECUTER; RegW=1 only in ALUWB.
- Op=01, Funct=6'b011001 (LDR imm), MemReady low for 2 cycles in MEMREAD -> state stays MEMREAD for 3 cycles with AdrSrc=1; then MEMWB with ResultSrc=01, RegW=1.
- Op=01, Funct=6'b011000 (STR), MemReady=0 for 1 cycle in FETCH and 2 cycles in MEMWRITE:
  - NextPC=IRWrite=0 on the stalled FETCH cycle.
  - MemW=1 for all 3 MEMWRITE cycles.
  - Returns to FETCH after MemReady=1.
- Op=10 (B) -> FETCH, DECODE, BRANCH, FETCH. Branch=1, ResultSrc=10, ALUSrcB=01 in BRANCH.
- Op=11 -> UNKNOWN for one cycle with Illegal=1 and all enables 0, then FETCH. Also assert reset=0 while in MEMWRITE -> MemW drops the same cycle and State=FETCH.
